oled_text_terminal: RTL and testbench



---
 rtl/oled_text_terminal.sv | 164 ++++++++++++++++
 tb/tb_oled_text_terminal.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/oled_text_terminal.sv
// oled_text_terminal
//   Character terminal that owns the text grid driving the OLED controller's
//   flattened ASCII bus. Bytes arrive over a valid/ready handshake. Printable
//   bytes are written at the cursor. LF, CR, BS and FF move the cursor or clear
//   the screen. When the grid overflows it either scrolls up or wraps to row 0.
//   o_DIRTY tells the display side that a redraw is needed.
// Ports:
//   i_CLK, i_RST         clock, synchronous active-high reset
//   i_CHAR/i_VALID       input byte and its valid; accepted when o_READY is high
//   o_READY              high only in IDLE
//   i_DRAW_DONE          one-cycle pulse, clears o_DIRTY
//   o_ASCII              grid, row 0 col 0 in the most significant byte
//   o_DIRTY              grid changed since the last i_DRAW_DONE
//   o_CURSOR_COL/_ROW    cursor position
module oled_text_terminal #(
  parameter int NUM_ASCII_COL = 12,
  parameter int NUM_ASCII_ROW = 8,
  parameter int AUTO_SCROLL   = 1,
  parameter int COL_W         = $clog2(NUM_ASCII_COL),
  parameter int ROW_W         = $clog2(NUM_ASCII_ROW)
) (
  input  logic                                   i_CLK,
  input  logic                                   i_RST,
  input  logic [7:0]                             i_CHAR,
  input  logic                                   i_VALID,
  output logic                                   o_READY,
  input  logic                                   i_DRAW_DONE,
  output logic [NUM_ASCII_COL*NUM_ASCII_ROW*8-1:0] o_ASCII,
  output logic                                   o_DIRTY,
  output logic [COL_W-1:0]                       o_CURSOR_COL,
  output logic [ROW_W-1:0]                       o_CURSOR_ROW
);
  localparam int TOTAL = NUM_ASCII_COL * NUM_ASCII_ROW;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_ASCII_COL - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ASCII_ROW - 1);

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;   // row being processed in SCROLL/CLEAR
  logic             dirty_q, dirty_d;
  logic [7:0]       grid_q [NUM_ASCII_ROW][NUM_ASCII_COL];

  logic             wr_en, set_dirty, adv, accept;
  logic [7:0]       wr_byte;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] src_row;

  assign o_READY      = (state_q == IDLE);
  assign o_DIRTY      = dirty_q;
  assign o_CURSOR_COL = col_q;
  assign o_CURSOR_ROW = row_q;
  assign accept       = i_VALID && (state_q == IDLE);
  // The source index is held at the last row on the final scroll cycle so it
  // never points past the grid; that row is filled with spaces anyway.
  assign src_row      = (cnt_q == LAST_ROW) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    dirty_d   = dirty_q;
    wr_en     = 1'b0;
    wr_byte   = 8'h20;
    wr_col    = col_q;
    set_dirty = 1'b0;
    adv       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (i_CHAR >= 8'h20 && i_CHAR <= 8'h7E) begin
            wr_en     = 1'b1;
            wr_byte   = i_CHAR;
            set_dirty = 1'b1;
            if (col_q < LAST_COL) col_d = col_q + 1'b1;
            else begin
              col_d = '0;
              adv   = 1'b1;
            end
          end else begin
            case (i_CHAR)
              8'h0A: begin
                col_d = '0;
                adv   = 1'b1;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                // Backspace stops at column 0; it never climbs to the previous row.
                if (col_q != '0) begin
                  col_d     = col_q - 1'b1;
                  wr_col    = col_q - 1'b1;
                  wr_en     = 1'b1;
                  set_dirty = 1'b1;
                end
              end
              8'h0C: begin
                col_d   = '0;
                row_d   = '0;
                state_d = CLEAR;
              end
              default: ;
            endcase
          end
          if (adv) begin
            if (row_q < LAST_ROW)    row_d   = row_q + 1'b1;
            else if (AUTO_SCROLL != 0) state_d = SCROLL;
            else                     row_d   = '0;
          end
        end
      end
      SCROLL, CLEAR: begin
        if (cnt_q == LAST_ROW) begin
          state_d   = IDLE;
          set_dirty = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new change outranks a simultaneous redraw-done.
    if (i_DRAW_DONE) dirty_d = 1'b0;
    if (set_dirty)   dirty_d = 1'b1;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      dirty_q <= 1'b1;
      for (int r = 0; r < NUM_ASCII_ROW; r++)
        for (int c = 0; c < NUM_ASCII_COL; c++)
          grid_q[r][c] <= 8'h20;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      if (wr_en) grid_q[row_q][wr_col] <= wr_byte;
      if (state_q == SCROLL) begin
        for (int c = 0; c < NUM_ASCII_COL; c++)
          grid_q[cnt_q][c] <= (cnt_q == LAST_ROW) ? 8'h20 : grid_q[src_row][c];
      end
      if (state_q == CLEAR) begin
        for (int c = 0; c < NUM_ASCII_COL; c++)
          grid_q[cnt_q][c] <= 8'h20;
      end
    end
  end

  // Flatten: row 0 col 0 lands in the top byte, like a string literal.
  for (genvar r = 0; r < NUM_ASCII_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_ASCII_COL; c++) begin : g_col
      assign o_ASCII[TOTAL*8-1-(r*NUM_ASCII_COL+c)*8 -: 8] = grid_q[r][c];
    end
  end
endmodule

// File: tb/tb_oled_text_terminal.sv
module tb_oled_text_terminal;
  localparam int NC  = 12;
  localparam int NR  = 8;
  localparam int TOT = NC * NR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst0, v0, dd0, rst1, v1, dd1;
  logic [7:0]     c0, c1;
  logic           r0, r1, dirty0, dirty1;
  logic [TOT*8-1:0] a0, a1;
  logic [3:0]     col0, col1;
  logic [2:0]     row0, row1;

  int checks = 0;
  int failures = 0;
  logic [7:0] e0 [TOT];
  logic [7:0] e1 [TOT];

  oled_text_terminal #(.NUM_ASCII_COL(NC), .NUM_ASCII_ROW(NR), .AUTO_SCROLL(1)) u_scr (
    .i_CLK(clk), .i_RST(rst0), .i_CHAR(c0), .i_VALID(v0), .o_READY(r0),
    .i_DRAW_DONE(dd0), .o_ASCII(a0), .o_DIRTY(dirty0),
    .o_CURSOR_COL(col0), .o_CURSOR_ROW(row0));

  oled_text_terminal #(.NUM_ASCII_COL(NC), .NUM_ASCII_ROW(NR), .AUTO_SCROLL(0)) u_wrap (
    .i_CLK(clk), .i_RST(rst1), .i_CHAR(c1), .i_VALID(v1), .o_READY(r1),
    .i_DRAW_DONE(dd1), .o_ASCII(a1), .o_DIRTY(dirty1),
    .o_CURSOR_COL(col1), .o_CURSOR_ROW(row1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Number of cells whose DUT byte differs from the bench's expected grid.
  function automatic int mism(input int u);
    int m = 0;
    logic [7:0] b;
    for (int i = 0; i < TOT; i++) begin
      b = (u == 0) ? a0[TOT*8-1-i*8 -: 8] : a1[TOT*8-1-i*8 -: 8];
      if (b !== ((u == 0) ? e0[i] : e1[i])) m++;
    end
    return m;
  endfunction

  function automatic logic rdy(input int u);
    return (u == 0) ? r0 : r1;
  endfunction

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input int u, input logic [7:0] ch);
    int n = 0;
    if (u == 0) begin c0 = ch; v0 = 1'b1; end
    else        begin c1 = ch; v1 = 1'b1; end
    while (!rdy(u) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("send_timeout", n, 0);
    @(negedge clk);
    if (u == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic gap(input int u, output int n);
    n = 0;
    while (!rdy(u) && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic pulse_dd0();
    dd0 = 1'b1;
    @(negedge clk);
    dd0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int n, low;
    rst0 = 1; rst1 = 1; v0 = 0; v1 = 0; dd0 = 0; dd1 = 0; c0 = 0; c1 = 0;
    for (int i = 0; i < TOT; i++) begin e0[i] = 8'h20; e1[i] = 8'h20; end
    repeat (2) @(negedge clk);
    rst0 = 0; rst1 = 0;
    repeat (5) @(negedge clk);

    // reset state
    chk("rst_grid", mism(0), 0);
    chk("rst_col", col0, 0);
    chk("rst_row", row0, 0);
    chk("rst_dirty", dirty0, 1);
    chk("rst_ready", r0, 1);
    chk("rst_grid_w", mism(1), 0);
    chk("rst_dirty_w", dirty1, 1);
    pulse_dd0();
    chk("dd_clear", dirty0, 0);

    // printable text
    s = "JAKE";
    for (int i = 0; i < 4; i++) begin send(0, s[i]); e0[i] = s[i]; end
    chk("jake_grid", mism(0), 0);
    chk("jake_col", col0, 4);
    chk("jake_row", row0, 0);
    chk("jake_dirty", dirty0, 1);

    // backspace
    send(0, 8'h08); e0[3] = 8'h20;
    chk("bs_grid", mism(0), 0);
    chk("bs_col", col0, 3);

    // CR, LF: cursor only, no dirty
    pulse_dd0();
    send(0, 8'h0D); send(0, 8'h0A);
    chk("crlf_col", col0, 0);
    chk("crlf_row", row0, 1);
    chk("crlf_grid", mism(0), 0);
    chk("crlf_dirty", dirty0, 0);

    // form feed clear
    send(0, 8'h0C);
    gap(0, n);
    chk("ff_gap", n, 8);
    for (int i = 0; i < TOT; i++) e0[i] = 8'h20;
    chk("ff_grid", mism(0), 0);
    chk("ff_col", col0, 0);
    chk("ff_row", row0, 0);
    chk("ff_dirty", dirty0, 1);

    // row wrap on column overflow
    for (int i = 0; i < NC; i++) begin send(0, "A"); e0[i] = "A"; end
    chk("wrap_grid", mism(0), 0);
    chk("wrap_col", col0, 0);
    chk("wrap_row", row0, 1);
    pulse_dd0();
    send(0, 8'h08);
    chk("bs0_col", col0, 0);
    chk("bs0_row", row0, 1);
    chk("bs0_grid", mism(0), 0);
    chk("bs0_dirty", dirty0, 0);

    // full screen with auto scroll, byte held during scroll
    send(0, 8'h0C);
    for (int i = 0; i < TOT; i++) e0[i] = 8'(8'h30 + i / NC);
    for (int i = 0; i < TOT - 1; i++) send(0, e0[i]);
    send(0, e0[TOT-1]);
    c0 = "Q"; v0 = 1'b1;
    chk("scr_ready0", r0, 0);
    chk("scr_col", col0, 0);
    chk("scr_row", row0, 7);
    gap(0, n);
    chk("scr_gap", n, 8);
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 0; i < TOT - NC; i++) e0[i] = e0[i+NC];
    for (int i = TOT - NC; i < TOT; i++) e0[i] = 8'h20;
    e0[TOT-NC] = "Q";
    chk("scr_grid", mism(0), 0);
    chk("scr_q_col", col0, 1);
    chk("scr_q_row", row0, 7);
    chk("scr_dirty", dirty0, 1);

    // wrap mode: no scroll, back to (0,0), text kept
    low = 0;
    for (int i = 0; i < TOT; i++) e1[i] = 8'(8'h30 + i / NC);
    for (int i = 0; i < TOT; i++) begin
      send(1, e1[i]);
      if (!r1) low++;
    end
    chk("w_nogap", low, 0);
    chk("w_col", col1, 0);
    chk("w_row", row1, 0);
    chk("w_grid", mism(1), 0);
    send(1, "Z"); e1[0] = "Z";
    chk("w_z_grid", mism(1), 0);
    chk("w_z_col", col1, 1);

    // reset in the middle of a clear
    pulse_dd0();
    send(0, 8'h0C);
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < TOT; i++) e0[i] = 8'h20;
    chk("rc_ready", r0, 1);
    chk("rc_col", col0, 0);
    chk("rc_row", row0, 0);
    chk("rc_dirty", dirty0, 1);
    chk("rc_grid", mism(0), 0);
    rst0 = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
